// File: rtl/multiport_regfile_if.sv
// rtl/multiport_regfile_if.sv - read/write/reserve bus between pipeline and multiport_regfile
interface multiport_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*ADDR_W-1:0] wr_addr;
    logic [NWR*DATA_W-1:0] wr_data;
    logic                  res_en;
    logic [ADDR_W-1:0]     res_addr;
    logic                  wr_conflict;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, res_en, res_addr,
        input  rd_data, rd_busy, wr_conflict
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, res_en, res_addr,
        output rd_data, rd_busy, wr_conflict
    );
endinterface

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - multi-read/multi-write register file with bypass and busy scoreboard
module multiport_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    multiport_regfile_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic              conflict_q;

    logic [ADDR_W-1:0] wa [NWR];
    logic [DATA_W-1:0] wd [NWR];
    logic [NWR-1:0]    we;
    logic              collide;
    logic              res_ok;

    logic [ADDR_W-1:0]     ra [NRD];
    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD-1:0]        rd_busy_c;

    // Writes to the hardwired zero register are removed here so they neither
    // commit, clear busy, forward, nor count as a collision.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wa[j] = bus.wr_addr[j*ADDR_W +: ADDR_W];
            wd[j] = bus.wr_data[j*DATA_W +: DATA_W];
            we[j] = bus.wr_en[j] && !(ZERO_REG && (wa[j] == '0));
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (we[i] && we[j] && (wa[i] == wa[j])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    assign res_ok = bus.res_en && !(ZERO_REG && (bus.res_addr == '0));

    // Later ports are scheduled after earlier ones, so the highest index wins a
    // collision; the reservation comes last so a new producer keeps busy set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j]) begin
                    regs[wa[j]] <= wd[j];
                    busy[wa[j]] <= 1'b0;
                end
            end
            if (res_ok) begin
                busy[bus.res_addr] <= 1'b1;
            end
            if (collide) begin
                conflict_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NRD; k++) begin
            ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
            rd_data_c[k*DATA_W +: DATA_W] = regs[ra[k]];
            rd_busy_c[k] = busy[ra[k]];
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j] == ra[k])) begin
                        rd_data_c[k*DATA_W +: DATA_W] = wd[j];
                        rd_busy_c[k] = 1'b0;
                    end
                end
            end
            if (ZERO_REG && (ra[k] == '0)) begin
                rd_data_c[k*DATA_W +: DATA_W] = '0;
            end
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_busy     = rd_busy_c;
    assign bus.wr_conflict = conflict_q;
endmodule

// File: doc/multiport_regfile.md
Name: multiport_regfile

Overview:
- Parametrised successor to the single-write 32x32 register file.
- Configurable width, depth, and number of read and write ports.
- Per-port write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard for multi-cycle producers.
- Sits between decode (reads, reservations) and writeback (writes) in the RISC pipeline; asynchronous reset clears all architectural state.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth NREG = 2**ADDR_W
- NRD, 2, number of read ports
- NWR, 2, number of write ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  busy status of each read address, combinational
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*ADDR_W  write addresses
- wr_data  in  NWR*DATA_W  write data
- res_en  in  1  reserve request: mark res_addr busy
- res_addr  in  ADDR_W  register to reserve
- wr_conflict  out  1  sticky flag: two enabled write ports hit the same address in one cycle

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately without a clock edge):
  - all NREG registers = 0, all busy bits = 0, wr_conflict = 0.
  - Writes and reservations are ignored while rst is high.
  - Reset asserted mid-cycle during a write discards that write.
- Write: on a rising clk edge, each port j with wr_en[j]=1 updates REG[wr_addr[j]] <= wr_data[j].
  - Same-address collision: the highest-indexed enabled port wins.
  - On a collision between enabled ports, wr_conflict is set at that edge and stays 1 until rst.
  - With ZERO_REG=1, writes to address 0 are dropped and do not set wr_conflict.
- Read: rd_data[k] is combinational with zero-cycle latency.
  - Priority 1: ZERO_REG=1 and rd_addr[k]=0 -> 0.
  - Priority 2: BYPASS=1 and some enabled write port matches rd_addr[k] -> that port's wr_data (highest index wins).
  - Otherwise -> REG[rd_addr[k]].
  - Every read port resolves independently; a match on one port never blocks another port, unlike the single-port predecessor.
  - BYPASS=0: reads return pre-edge contents; the new value is visible the cycle after the write.
- Scoreboard (NREG busy bits):
  - res_en=1 at an edge sets busy[res_addr].
  - An enabled write to address a at an edge clears busy[a].
  - Reserve and write to the same address at the same edge: busy ends 1 (the new producer wins); write data is still committed.
  - Reserve of address 0 with ZERO_REG=1 is ignored.
  - rd_busy[k] = busy[rd_addr[k]] & ~(BYPASS & any enabled write matching rd_addr[k] this cycle). A value being forwarded is therefore not reported busy.
- Address range: all addresses are 0..NREG-1 by construction; no out-of-range case exists.
- Simultaneous read and write of the same address without bypass: old data is returned, and busy reflects pre-edge state.

Test Plan:
- Reset clear:
  - Stimulus: write REG3=0xDEAD_BEEF; pulse rst between clk edges; read addr 3.
  - Required: rd_data=0 immediately, rd_busy=0, wr_conflict=0.
- Dual write and bypass:
  - Stimulus: one edge with wr_en=2'b11, port0 {5, 0x11}, port1 {6, 0x22}; rd_addr={5,6} during that cycle.
  - Required: BYPASS=1 reads 0x11/0x22 the same cycle. BYPASS=0 reads the old values, then 0x11/0x22 after the edge.
- Write collision:
  - Stimulus: port0 {9, 0xAAAA}, port1 {9, 0xBBBB} at the same edge.
  - Required: REG9=0xBBBB and wr_conflict=1, which persists until rst.
- Zero register:
  - Stimulus: write {0, 0xFFFF_FFFF} and res_en with res_addr=0.
  - Required: rd_data for addr 0 = 0, rd_busy=0, wr_conflict=0. A simultaneous port0 and port1 write to addr 0 also leaves wr_conflict=0.
- Scoreboard lifecycle:
  - Stimulus: reserve reg 7 (edge 1); read 7 at cycle 2.
  - Required: rd_busy=1 at cycle 2.
  - Stimulus: write {7, 0x55} at edge 3.
  - Required: during cycle 3, rd_busy=0 and rd_data=0x55 (bypass); after edge 3, busy[7]=0.
- Reserve plus write race:
  - Stimulus: at the same edge, res_en with res_addr=4 and write {4, 0x99}.
  - Required: REG4=0x99 and rd_busy for addr 4 = 1 after the edge, until a later write to 4.
